// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bundles the two request channels, the ALU operand and
// result ports, and the tagged response channel of alu_share_arbiter.
// slave = arbiter side, master = surrounding datapath / testbench side.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zf;
  logic              alu_sf;
  logic              alu_cf;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zf;
  logic              rsp_sf;
  logic              rsp_cf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_zf, alu_sf, alu_cf,
    output rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_cf,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_zf, alu_sf, alu_cf,
    input  rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_cf,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between the main pipe (requester 0) and the
// address-gen unit (requester 1). One operation in flight: IDLE accepts,
// EXEC lets the ALU evaluate the latched operands and captures result/flags,
// RESP holds the tagged response until the consumer takes it.
// Optional feature macro ALU_ARB_RR_EN: round-robin tie-break instead of
// fixed priority to requester 0.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input logic          clk,
  input logic          rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              id_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zf_q;
  logic              rsp_sf_q;
  logic              rsp_cf_q;

  logic              grant1;
  logic              take;

`ifdef ALU_ARB_RR_EN
  logic              last_grant;
`endif

  // Arbitration: pick the winner from the current valids, re-evaluated every cycle.
  always_comb begin
`ifdef ALU_ARB_RR_EN
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
`else
    grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
    take = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
  end

  assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant1;
  assign bus.req1_ready = (state == IDLE) & grant1;

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zf     = rsp_zf_q;
  assign bus.rsp_sf     = rsp_sf_q;
  assign bus.rsp_cf     = rsp_cf_q;

  // Control FSM with registered ALU operands and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zf_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
      rsp_cf_q     <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            alu_a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
            alu_b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
            alu_op_q <= grant1 ? bus.req1_op : bus.req0_op;
            id_q     <= grant1;
`ifdef ALU_ARB_RR_EN
            last_grant <= grant1;
`endif
            state    <= EXEC;
          end
        end
        EXEC: begin
          // rsp_id is loaded here rather than at accept so it never changes
          // underneath a response the consumer may still be looking at.
          rsp_result_q <= bus.alu_result;
          rsp_zf_q     <= bus.alu_zf;
          rsp_sf_q     <= bus.alu_sf;
          rsp_cf_q     <= bus.alu_cf;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: drives both requesters, models the external ALU,
// and scores every response against a queue of expected results built from
// the arbitration policy and ALU arithmetic at accept time.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU arithmetic: returns {cf, sf, zf, result}
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [32:0] t;
    logic [31:0] r;
    logic        c;
    int unsigned sh;
    sh = b[4:0];
    r = '0;
    c = 1'b0;
    t = '0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32]; end
      3'd1: begin t = {1'b0, a} << sh;       r = t[31:0]; c = t[32]; end
      3'd2: begin t = {1'b0, a} - {1'b0, b}; r = t[31:0]; c = t[32]; end
      3'd3: begin r = '0; c = 1'b0; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: begin t = {a, 1'b0} >> sh; r = t[32:1]; c = t[0]; end
    endcase
    return {c, r[31], (r == 32'd0), r};
  endfunction

  // External ALU: combinational on the arbiter's registered operands
  logic [34:0] alu_out;
  assign alu_out        = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
  assign bus.alu_result = alu_out[31:0];
  assign bus.alu_zf     = alu_out[32];
  assign bus.alu_sf     = alu_out[33];
  assign bus.alu_cf     = alu_out[34];

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [2:0]  fl;   // {zf, sf, cf}
  } exp_t;

  exp_t  q[$];
  logic  id_log[$];
  bit    busy = 1'b0;
  bit    last_g = 1'b1;
  bit    seen_v = 1'b0;
  bit    have_prev = 1'b0;
  bit    rsp_done;
  bit    g1;
  int    cyc = 0;
  int    hs_cyc = 0;
  logic [35:0] prev_rsp;
  logic [35:0] cur_rsp;
  logic [34:0] f;
  exp_t  e;

  // Monitor / scoreboard, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      busy = 1'b0;
      last_g = 1'b1;
      have_prev = 1'b0;
      seen_v = 1'b0;
    end else begin
      rsp_done = 1'b0;
      cur_rsp = {bus.rsp_id, bus.rsp_result, bus.rsp_zf, bus.rsp_sf, bus.rsp_cf};
      if (bus.rsp_valid) begin
        chk("rsp_without_op", {63'd0, busy}, 64'd1);
        if (!seen_v) begin
          chk("latency", 64'(cyc - hs_cyc), 64'd2);
          seen_v = 1'b1;
        end
        if (have_prev) chk("rsp_stable", {28'd0, cur_rsp}, {28'd0, prev_rsp});
        chk("ready_in_resp", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        if (bus.rsp_ready) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
            chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, e.res});
            chk("rsp_flags", {61'd0, bus.rsp_zf, bus.rsp_sf, bus.rsp_cf}, {61'd0, e.fl});
          end
          id_log.push_back(bus.rsp_id);
          have_prev = 1'b0;
          rsp_done = 1'b1;
        end else begin
          prev_rsp = cur_rsp;
          have_prev = 1'b1;
        end
      end else begin
        if (have_prev) chk("rsp_valid_held", {63'd0, bus.rsp_valid}, 64'd1);
        have_prev = 1'b0;
        if (busy && !seen_v && (cyc - hs_cyc) > 2) begin
          chk("latency_timeout", 64'(cyc - hs_cyc), 64'd2);
          seen_v = 1'b1;
        end
      end

      if (busy) begin
        if (!bus.rsp_valid)
          chk("ready_while_busy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      end else if (bus.req0_valid || bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
        g1 = bus.req1_valid && (!bus.req0_valid || !last_g);
`else
        g1 = bus.req1_valid && !bus.req0_valid;
`endif
        chk("grant", {62'd0, bus.req1_ready, bus.req0_ready}, g1 ? 64'd2 : 64'd1);
        f = g1 ? alu_fn(bus.req1_a, bus.req1_b, bus.req1_op)
               : alu_fn(bus.req0_a, bus.req0_b, bus.req0_op);
        e.id  = g1;
        e.res = f[31:0];
        e.fl  = {f[32], f[33], f[34]};
        q.push_back(e);
        busy   = 1'b1;
        hs_cyc = cyc;
        seen_v = 1'b0;
        last_g = g1;
      end
      if (rsp_done) busy = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rsp_valid"},  {63'd0, bus.rsp_valid}, 64'd0);
    chk({nm, "_rsp_id"},     {63'd0, bus.rsp_id}, 64'd0);
    chk({nm, "_rsp_result"}, {32'd0, bus.rsp_result}, 64'd0);
    chk({nm, "_rsp_flags"},  {61'd0, bus.rsp_zf, bus.rsp_sf, bus.rsp_cf}, 64'd0);
    chk({nm, "_alu_a"},      {32'd0, bus.alu_a}, 64'd0);
    chk({nm, "_alu_b"},      {32'd0, bus.alu_b}, 64'd0);
    chk({nm, "_alu_opcode"}, {61'd0, bus.alu_opcode}, 64'd0);
  endtask

  task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic wait_accept(input bit id, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready))
        got = 1'b1;
    end
    if (!got) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    if (busy) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // One isolated request with hand-computed expected response
  task automatic directed(input string nm, input bit id, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] exp_res, input logic [2:0] exp_fl);
    bit got;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    set_req(id, a, b, op);
    wait_accept(id, nm);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = 1'b1;
        chk({nm, "_id"},     {63'd0, bus.rsp_id}, {63'd0, id});
        chk({nm, "_result"}, {32'd0, bus.rsp_result}, {32'd0, exp_res});
        chk({nm, "_flags"},  {61'd0, bus.rsp_zf, bus.rsp_sf, bus.rsp_cf}, {61'd0, exp_fl});
      end
    end
    if (!got) chk({nm, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // flags listed as {zf, sf, cf}
    directed("add_carry", 1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'h0000_0000, 3'b101);
    directed("sub_neg",   1'b1, 32'd5,         32'd7, 3'd2, 32'hFFFF_FFFE, 3'b011);
    directed("shl",       1'b0, 32'h8000_0001, 32'd1, 3'd1, 32'h0000_0002, 3'b001);
    directed("undef_op",  1'b1, 32'h1234,      32'h5678, 3'd3, 32'h0000_0000, 3'b100);

    // Tie: both valid continuously; previous winner was requester 1
    @(posedge clk); #1;
    id_log.delete();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 32'd10, 32'd20, 3'd0);
    set_req(1'b1, 32'hF0F0, 32'h0FF0, 3'd6);
    for (int i = 0; i < 60 && id_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      chk("tie_id", (i < id_log.size()) ? {63'd0, id_log[i]} : 64'hDEAD, 64'(i % 2));
`else
      chk("tie_id", (i < id_log.size()) ? {63'd0, id_log[i]} : 64'hDEAD, 64'd0);
`endif
    end
    drain();

    // Backpressure: response stalled, requester 1 waiting behind it
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 32'hCAFE_0000, 32'h0000_BEEF, 3'd5);
    wait_accept(1'b0, "bp");
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    set_req(1'b1, 32'd100, 32'd3, 3'd7);
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      saw = bus.rsp_valid;
    end
    chk("bp_rsp_valid", {63'd0, saw}, 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {63'd0, bus.req1_ready}, 64'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // Reset during EXEC drops the operation
    @(posedge clk); #1;
    set_req(1'b0, 32'd7, 32'd9, 3'd0);
    wait_accept(1'b0, "rst_mid");
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    chk("rst_mid_no_rsp", {63'd0, saw}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      bus.req0_valid = ($urandom_range(0, 99) < 55);
      bus.req0_a     = rnd_operand();
      bus.req0_b     = rnd_operand();
      bus.req0_op    = 3'($urandom_range(0, 7));
      bus.req1_valid = ($urandom_range(0, 99) < 55);
      bus.req1_a     = rnd_operand();
      bus.req1_b     = rnd_operand();
      bus.req1_op    = 3'($urandom_range(0, 7));
      bus.rsp_ready  = ($urandom_range(0, 99) < 65);
    end
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
